dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port. It accepts one load/store request at a time over a valid/ready handshake. After a programmable wait it services the request against an internal 64-bit-word storage array and returns a response over a second valid/ready handshake. It lets the datapath run against non-ideal, multi-cycle memory in place of the zero-latency combinational data memory.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_storage_array.sv | 19 +
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, address geometry and the request legality check
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WORD_BYTES = 8;
  localparam int ADDR_LSB = $clog2(WORD_BYTES);
  function automatic logic addr_err(input logic [63:0] addr, input int depth);
    return (addr[ADDR_LSB-1:0] != '0) || ({{ADDR_LSB{1'b0}}, addr[63:ADDR_LSB]} >= 64'(depth));
  endfunction
endpackage

// File: rtl/dmem_storage_array.sv
// dmem_storage_array: single-port 64-bit word store, synchronous write, registered read, no reset
module dmem_storage_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           CLK,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [63:0]                    wdata,
  output logic [63:0]                    rdata
);
  logic [63:0] r_mem [DEPTH_WORDS];
  // read data register only moves on a read, so it holds steady while a response waits
  always_ff @(posedge CLK)
    if (en) begin
      if (we) r_mem[index] <= wdata;
      else rdata <= r_mem[index];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable access latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic r_req_ready, r_resp_valid, r_resp_err, r_rd_sel, r_write;
  logic [63:0] r_addr, r_wdata, w_addr, w_wdata, w_rdata;
  logic w_write, w_err, w_access;
  // with zero latency the access happens on the accept edge, so use the live request
  assign w_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_write = (r_state == IDLE) ? req_write : r_write;
  assign w_err = addr_err(w_addr, DEPTH_WORDS);
  assign req_ready = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_error = r_resp_err;
  assign resp_rdata = r_rd_sel ? w_rdata : '0;
  dmem_storage_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .CLK  (CLK),
    .en   (w_access && !w_err),
    .we   (w_write),
    .index(w_addr[ADDR_LSB +: IW]),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );
  // next state and the edge on which the array is accessed
  always_comb begin
    w_state_nxt = r_state;
    w_access = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_access = (LATENCY == 0);
        w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: if (r_cnt == '0) begin
        w_access = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state, captured request, wait counter and registered response flags
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_req_ready <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err <= 1'b0;
      r_rd_sel <= 1'b0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      if (r_state == IDLE && req_valid) begin
        r_write <= req_write;
        r_addr <= req_addr;
        r_wdata <= req_wdata;
        r_cnt <= CW'(LATENCY - 1);
      end else if (r_state == WAIT) r_cnt <= r_cnt - 1'b1;
      if (w_access) begin
        r_resp_err <= w_err;
        r_rd_sel <= !w_err && !w_write;
      end else if (r_state == RESP && resp_ready) begin
        r_resp_err <= 1'b0;
        r_rd_sel <= 1'b0;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
module tb_dmem_responder;
  logic CLK = 1'b0, reset = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic rr0, rv0, re0, rr1, rv1, re1;
  logic [63:0] rd0, rd1;
  logic o_rr, o_rv, o_re;
  logic [63:0] o_rd;
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .CLK(CLK), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready && !sel), .resp_rdata(rd0), .resp_error(re0));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_l0 (
    .CLK(CLK), .reset(reset), .req_valid(req_valid && sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready && sel), .resp_rdata(rd1), .resp_error(re1));
  assign o_rr = sel ? rr1 : rr0;
  assign o_rv = sel ? rv1 : rv0;
  assign o_re = sel ? re1 : re0;
  assign o_rd = sel ? rd1 : rd0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " req_ready"}, 64'(o_rr), 64'd1);
    chk({tag, " resp_valid"}, 64'(o_rv), 64'd0);
    chk({tag, " rdata"}, o_rd, 64'd0);
    chk({tag, " error"}, 64'(o_re), 64'd0);
  endtask
  task automatic xact(input string tag, input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                      input int lat, input logic [63:0] exp_rd, input logic exp_err, input int hold);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_wdata = wdata;
    chk({tag, " ready at request"}, 64'(o_rr), 64'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    req_addr = 64'hBAD0_BAD0_BAD0_BAD0;
    req_wdata = '1;
    n = 1;
    while (!o_rv && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " rdata"}, o_rd, exp_rd);
    chk({tag, " error"}, 64'(o_re), 64'(exp_err));
    chk({tag, " ready busy"}, 64'(o_rr), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, " held valid"}, 64'(o_rv), 64'd1);
      chk({tag, " held rdata"}, o_rd, exp_rd);
      chk({tag, " held error"}, 64'(o_re), 64'(exp_err));
      chk({tag, " held ready"}, 64'(o_rr), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    chk_idle({tag, " after consume"});
  endtask
  initial begin
    #1 reset = 1'b1;
    @(negedge CLK);
    chk_idle("in reset");
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk_idle("idle no request");
    xact("st 0x10", 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 3, 64'h0, 1'b0, 0);
    xact("ld 0x10", 1'b0, 64'h10, 64'h0, 3, 64'hDEADBEEFCAFEF00D, 1'b0, 0);
    xact("ld 0x13", 1'b0, 64'h13, 64'h0, 3, 64'h0, 1'b1, 0);
    xact("st 0x2000", 1'b1, 64'h2000, 64'h5555, 3, 64'h0, 1'b1, 0);
    xact("ld 0x2000", 1'b0, 64'h2000, 64'h0, 3, 64'h0, 1'b1, 0);
    xact("ld 0x10 again", 1'b0, 64'h10, 64'h0, 3, 64'hDEADBEEFCAFEF00D, 1'b0, 0);
    xact("st 0x20", 1'b1, 64'h20, 64'hAAAA, 3, 64'h0, 1'b0, 0);
    xact("ld 0x20 bp", 1'b0, 64'h20, 64'h0, 3, 64'hAAAA, 1'b0, 3);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 64'h20;
    req_wdata = 64'h1111;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("wait before reset", 64'(o_rr), 64'd0);
    reset = 1'b1;
    #1;
    chk_idle("reset in wait");
    #1 reset = 1'b0;
    repeat (4) @(negedge CLK);
    chk_idle("post reset idle");
    xact("ld 0x20 after reset", 1'b0, 64'h20, 64'h0, 3, 64'hAAAA, 1'b0, 0);
    sel = 1'b1;
    #1;
    chk_idle("l0 idle");
    xact("l0 st 0x08", 1'b1, 64'h08, 64'h0123456789ABCDEF, 1, 64'h0, 1'b0, 0);
    xact("l0 ld 0x08", 1'b0, 64'h08, 64'h0, 1, 64'h0123456789ABCDEF, 1'b0, 0);
    xact("l0 ld 0x0c", 1'b0, 64'h0C, 64'h0, 1, 64'h0, 1'b1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
